fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the pipelined RV32I core. Holds the program counter, addresses instruction memory, and loads the IF/ID pipeline register. Consumes the branch unit's redirect (`PcSel`, `BrPC`) from EX, inserts bubbles for squashed instructions, honours hazard-unit stalls, and optionally latches the halt instruction into a permanent halted state.

## Interface
Parameters:
- `PC_W`, 9, byte-address width of the PC; must match the branch unit's `PC_W`.
- `NOP_INSTR`, 32'h00000013, bubble encoding (`addi x0,x0,0`).

Ports:
- `clk` input 1: core clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `stall` input 1: hazard unit; hold PC and IF/ID.
- `PcSel` input 1: branch unit; 1 = redirect taken this cycle.
- `BrPC` input 32: branch unit redirect target.
- `halt_i` input 1: the instruction in EX has opcode 7'b1111111.
- `imem_rdata` input 32: instruction memory read data; combinational read of `pc_o`.
- `pc_o` output PC_W: current PC, drives the instruction memory address.
- `if_pc` output PC_W: IF/ID register, PC of the held instruction.
- `if_instr` output 32: IF/ID register, instruction.
- `if_valid` output 1: IF/ID register, 1 = real instruction, 0 = bubble.
- `flush_o` output 1: combinational; clear ID/EX on this edge.
- `halted` output 1: core is halted.
- `fetch_cnt` output 32: number of valid instructions loaded into IF/ID.

## Operation
- State: PC register, IF/ID register (`if_pc`, `if_instr`, `if_valid`), `fetch_cnt`, and a 2-state FSM: RUN and HALTED.
- Edge priority: `reset` > HALTED > `PcSel` > `stall` > normal.
- Normal (RUN, no `PcSel`, no `stall`): PC <= PC + 4 modulo 2^PC_W. IF/ID <= {`pc_o`, `imem_rdata`, 1}. `fetch_cnt` += 1.
- Stall (RUN, `stall`=1, `PcSel`=0): PC, IF/ID, and `fetch_cnt` hold their values.
- Redirect (RUN, `PcSel`=1): the redirect wins over `stall`, because the branch is older than the stalled instruction.
  - PC <= {`BrPC[PC_W-1:2]`, 2'b00}; `BrPC` bits [31:PC_W] and [1:0] are ignored.
  - IF/ID <= {`pc_o`, NOP_INSTR, 0}. `fetch_cnt` holds.
- `flush_o` = `PcSel` & (state == RUN). The IF/ID bubble and the ID/EX clear squash both wrong-path instructions.
- Wrap-around: PC = 2^PC_W − 4 steps to 0. `fetch_cnt` wraps from 32'hFFFFFFFF to 0.
- HALTED behaviour (see Configuration):
  - PC holds; IF/ID holds a bubble.
  - `PcSel`, `stall`, and `halt_i` are ignored. `flush_o` = 0. `fetch_cnt` holds.
  - Only `reset` leaves HALTED.

## Timing
- Reset values:
  - PC = `pc_o` = 0, `if_pc` = 0, `if_instr` = NOP_INSTR, `if_valid` = 0.
  - `halted` = 0, `fetch_cnt` = 0, FSM = RUN.
  - `flush_o` = 0 whenever `reset` is high.
- Reset asserted mid-stall or mid-redirect: the next edge applies reset values; pending `PcSel` and `stall` are discarded.
- Fetch latency: the instruction at `pc_o` appears in IF/ID one edge later. The first valid instruction (address 0) is in IF/ID on the first edge after `reset` falls.
- Redirect latency: with `PcSel`=1 before edge N, `pc_o` = target after N, and the target instruction is in IF/ID after N+1.
- `flush_o` is purely combinational from `PcSel` and the FSM state; no registered delay.
- `halted` is registered; it rises on the same edge as the PC load.

## Configuration
- `FETCH_HALT_LATCH_EN` defined:
  - When `PcSel` & `halt_i` in RUN, the FSM moves to HALTED on that edge.
  - PC <= target (the halt's own PC), IF/ID <= bubble, `halted` <= 1.
  - `flush_o` = 1 in that cycle only.
- Not defined:
  - `halt_i` is ignored, there is no HALTED state, and `halted` is tied to 0.
  - A halt then behaves as an ordinary redirect to itself: it re-fetches every 3 cycles, `flush_o` pulses, and `fetch_cnt` keeps counting.

## Test plan
- Reset release, with imem[0]=0xA, imem[4]=0xB, no stall: after edge 1, `if_instr`=0xA, `if_pc`=0, `if_valid`=1; after edge 2, `if_instr`=0xB, `if_pc`=4, `fetch_cnt`=2.
- `stall`=1 for 3 cycles at `pc_o`=8: `pc_o`, `if_*`, and `fetch_cnt` are unchanged for 3 edges, then resume with `pc_o`=12.
- `PcSel`=1, `BrPC`=0x40, and `stall`=1 in the same cycle at `pc_o`=0x10:
  - Same cycle: `flush_o`=1.
  - Next edge: `pc_o`=0x40, `if_valid`=0, `if_instr`=NOP_INSTR, `fetch_cnt` unchanged.
  - Following edge: `if_pc`=0x40, `if_valid`=1.
- Misaligned and wide target, `BrPC`=0xFFFF_F1F3 with PC_W=9: `pc_o`=0x1F0. Sequential fetch from `pc_o`=0x1FC wraps to 0.
- Halt: `PcSel`=1, `halt_i`=1, `BrPC`=0x20.
  - With `FETCH_HALT_LATCH_EN`: `halted`=1 and `pc_o`=0x20 are frozen for 10 cycles despite later `PcSel` pulses; `reset` returns everything to reset values.
  - Without the macro: `pc_o` revisits 0x20 every 3 cycles and `halted`=0.
- Counter wrap: force `fetch_cnt`=32'hFFFFFFFF, then one valid fetch gives `fetch_cnt`=0.

Source files
------------

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC register, imem addressing and IF/ID register.
// Define FETCH_HALT_LATCH_EN to latch a halt redirect into a permanent HALTED state.
module fetch_stage #(
  parameter int          PC_W      = 9,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            PcSel,
  input  logic [31:0]     BrPC,
  input  logic            halt_i,
  input  logic [31:0]     imem_rdata,
  output logic [PC_W-1:0] pc_o,
  output logic [PC_W-1:0] if_pc,
  output logic [31:0]     if_instr,
  output logic            if_valid,
  output logic            flush_o,
  output logic            halted,
  output logic [31:0]     fetch_cnt
);

  typedef enum logic {
    RUN,
    HALTED
  } state_t;

  state_t          state;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] target;
  logic            halt_go;

  assign pc_o   = pc_q;
  assign pc_inc = pc_q + PC_W'(4);
  assign target = {BrPC[PC_W-1:2], 2'b00};

`ifdef FETCH_HALT_LATCH_EN
  assign halt_go = PcSel & halt_i;
`else
  assign halt_go = 1'b0;
`endif

  // upper/lower target bits are dropped on purpose
  logic unused_ok;
  assign unused_ok = ^{halt_i, BrPC};

  assign flush_o = PcSel & ~reset & (state == RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      pc_q      <= '0;
      if_pc     <= '0;
      if_instr  <= NOP_INSTR;
      if_valid  <= 1'b0;
      halted    <= 1'b0;
      fetch_cnt <= '0;
    end else if (state == HALTED) begin
      state <= HALTED;
    end else if (PcSel) begin
      pc_q     <= target;
      if_pc    <= pc_q;
      if_instr <= NOP_INSTR;
      if_valid <= 1'b0;
      if (halt_go) begin
        state  <= HALTED;
        halted <= 1'b1;
      end
    end else if (!stall) begin
      pc_q      <= pc_inc;
      if_pc     <= pc_q;
      if_instr  <= imem_rdata;
      if_valid  <= 1'b1;
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage.
// Covers reset, stall, redirect, wrap, counter wrap and halt behaviour.
module tb_fetch_stage;

  localparam int          PC_W = 9;
  localparam logic [31:0] NOP  = 32'h00000013;

  logic            clk = 1'b0;
  logic            reset;
  logic            stall;
  logic            PcSel;
  logic [31:0]     BrPC;
  logic            halt_i;
  logic [31:0]     imem_rdata;
  logic [PC_W-1:0] pc_o;
  logic [PC_W-1:0] if_pc;
  logic [31:0]     if_instr;
  logic            if_valid;
  logic            flush_o;
  logic            halted;
  logic [31:0]     fetch_cnt;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [128];

  always #5 clk = ~clk;

  assign imem_rdata = mem[pc_o[PC_W-1:2]];

  fetch_stage #(.PC_W(PC_W), .NOP_INSTR(NOP)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .PcSel      (PcSel),
    .BrPC       (BrPC),
    .halt_i     (halt_i),
    .imem_rdata (imem_rdata),
    .pc_o       (pc_o),
    .if_pc      (if_pc),
    .if_instr   (if_instr),
    .if_valid   (if_valid),
    .flush_o    (flush_o),
    .halted     (halted),
    .fetch_cnt  (fetch_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    stall = 1'b0;
    PcSel = 1'b0;
    halt_i = 1'b0;
    BrPC = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    stall  = 1'b1;
    PcSel  = 1'b1;
    halt_i = 1'b1;
    BrPC   = 32'h40;
    tick();
    tick();
    total++;
    if (flush_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_flush got=%0b exp=0", flush_o);
    end
    total++;
    if ({pc_o, if_pc, if_instr, if_valid, halted, fetch_cnt} !==
        {9'h0, 9'h0, NOP, 1'b0, 1'b0, 32'h0}) begin
      bad++;
      $display("FAIL reset_vals pc=%h ifpc=%h instr=%h v=%b h=%b cnt=%0d",
               pc_o, if_pc, if_instr, if_valid, halted, fetch_cnt);
    end
    reset  = 1'b0;
    stall  = 1'b0;
    PcSel  = 1'b0;
    halt_i = 1'b0;
    tick();
    total++;
    if ({if_instr, if_pc, if_valid, pc_o} !== {32'hA, 9'h0, 1'b1, 9'h4}) begin
      bad++;
      $display("FAIL first_fetch instr=%h ifpc=%h v=%b pc=%h exp A/0/1/4",
               if_instr, if_pc, if_valid, pc_o);
    end
    tick();
    total++;
    if ({if_instr, if_pc, fetch_cnt} !== {32'hB, 9'h4, 32'd2}) begin
      bad++;
      $display("FAIL second_fetch instr=%h ifpc=%h cnt=%0d exp B/4/2",
               if_instr, if_pc, fetch_cnt);
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({pc_o, if_pc, if_instr, if_valid, fetch_cnt} !==
          {9'h8, 9'h4, 32'hB, 1'b1, 32'd2}) begin
        bad++;
        $display("FAIL stall_hold%0d pc=%h ifpc=%h instr=%h cnt=%0d",
                 i, pc_o, if_pc, if_instr, fetch_cnt);
      end
    end
    stall = 1'b0;
    tick();
    total++;
    if ({pc_o, if_pc, if_instr, fetch_cnt} !==
        {9'hC, 9'h8, 32'hC000_0008, 32'd3}) begin
      bad++;
      $display("FAIL stall_resume pc=%h ifpc=%h instr=%h cnt=%0d",
               pc_o, if_pc, if_instr, fetch_cnt);
    end
  endtask

  task automatic test_redirect();
    tick();
    PcSel = 1'b1;
    BrPC  = 32'h40;
    stall = 1'b1;
    #1;
    total++;
    if ({pc_o, flush_o} !== {9'h10, 1'b1}) begin
      bad++;
      $display("FAIL redir_flush pc=%h flush=%b exp 10/1", pc_o, flush_o);
    end
    tick();
    PcSel = 1'b0;
    stall = 1'b0;
    total++;
    if ({pc_o, if_valid, if_instr, if_pc, fetch_cnt} !==
        {9'h40, 1'b0, NOP, 9'h10, 32'd4}) begin
      bad++;
      $display("FAIL redir_bubble pc=%h v=%b instr=%h ifpc=%h cnt=%0d",
               pc_o, if_valid, if_instr, if_pc, fetch_cnt);
    end
    tick();
    total++;
    if ({if_pc, if_valid, if_instr, pc_o, fetch_cnt} !==
        {9'h40, 1'b1, 32'hC000_0040, 9'h44, 32'd5}) begin
      bad++;
      $display("FAIL redir_target ifpc=%h v=%b instr=%h pc=%h cnt=%0d",
               if_pc, if_valid, if_instr, pc_o, fetch_cnt);
    end
  endtask

  task automatic test_wrap();
    PcSel = 1'b1;
    BrPC  = 32'hFFFF_F1F3;
    tick();
    PcSel = 1'b0;
    total++;
    if ({pc_o, fetch_cnt} !== {9'h1F0, 32'd5}) begin
      bad++;
      $display("FAIL wide_target pc=%h cnt=%0d exp 1f0/5", pc_o, fetch_cnt);
    end
    for (int i = 0; i < 4; i++) tick();
    total++;
    if ({pc_o, if_pc, if_instr, fetch_cnt} !==
        {9'h0, 9'h1FC, 32'hC000_01FC, 32'd9}) begin
      bad++;
      $display("FAIL pc_wrap pc=%h ifpc=%h instr=%h cnt=%0d",
               pc_o, if_pc, if_instr, fetch_cnt);
    end
  endtask

  task automatic test_counter_wrap();
    stall = 1'b1;
    force dut.fetch_cnt = 32'hFFFF_FFFF;
    tick();
    release dut.fetch_cnt;
    #1;
    stall = 1'b0;
    tick();
    total++;
    if (fetch_cnt !== 32'd0) begin
      bad++;
      $display("FAIL cnt_wrap got=%h exp=0", fetch_cnt);
    end
  endtask

  task automatic test_halt();
    do_reset();
    tick();
    PcSel  = 1'b1;
    halt_i = 1'b1;
    BrPC   = 32'h20;
    #1;
    total++;
    if (flush_o !== 1'b1) begin
      bad++;
      $display("FAIL halt_flush got=%b exp=1", flush_o);
    end
    tick();
    PcSel  = 1'b0;
    halt_i = 1'b0;
`ifdef FETCH_HALT_LATCH_EN
    for (int i = 0; i < 10; i++) begin
      PcSel = (i % 3 == 0);
      stall = (i % 2 == 0);
      halt_i = (i == 4);
      BrPC  = 32'h80;
      #1;
      total++;
      if ({halted, pc_o, if_valid, if_instr, flush_o, fetch_cnt} !==
          {1'b1, 9'h20, 1'b0, NOP, 1'b0, 32'd1}) begin
        bad++;
        $display("FAIL halt_frozen%0d h=%b pc=%h v=%b fl=%b cnt=%0d",
                 i, halted, pc_o, if_valid, flush_o, fetch_cnt);
      end
      tick();
    end
    do_reset();
    #1;
    total++;
    if ({pc_o, if_pc, if_instr, if_valid, halted, fetch_cnt} !==
        {9'h0, 9'h0, NOP, 1'b0, 1'b0, 32'h0}) begin
      bad++;
      $display("FAIL halt_reset pc=%h v=%b h=%b cnt=%0d",
               pc_o, if_valid, halted, fetch_cnt);
    end
`else
    for (int r = 0; r < 3; r++) begin
      total++;
      if ({pc_o, halted, fetch_cnt} !== {9'h20, 1'b0, 32'(1 + 2 * r)}) begin
        bad++;
        $display("FAIL halt_refetch%0d pc=%h h=%b cnt=%0d",
                 r, pc_o, halted, fetch_cnt);
      end
      tick();
      tick();
      PcSel  = 1'b1;
      halt_i = 1'b1;
      BrPC   = 32'h20;
      tick();
      PcSel  = 1'b0;
      halt_i = 1'b0;
    end
`endif
  endtask

  task automatic test_back_to_back();
    do_reset();
    PcSel = 1'b1;
    BrPC  = 32'h100;
    tick();
    BrPC  = 32'h104;
    tick();
    PcSel = 1'b0;
    total++;
    if ({pc_o, if_pc, if_valid, fetch_cnt} !== {9'h104, 9'h100, 1'b0, 32'd0}) begin
      bad++;
      $display("FAIL b2b_redir pc=%h ifpc=%h v=%b cnt=%0d",
               pc_o, if_pc, if_valid, fetch_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'hC000_0000 + 32'(i * 4);
    mem[0] = 32'hA;
    mem[1] = 32'hB;
    test_reset();
    test_stall();
    test_redirect();
    test_wrap();
    test_counter_wrap();
    test_halt();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
